clock_works: RTL and testbench
==============================

CLOCK_WORKS -- requirements
Module: clock_works

Interface
REQ-001 Parameter SLOW, default 19, divider exponent; legal range 0..30; clk_out frequency = f(clk)/2^(SLOW+1).
REQ-002 Parameter RST_STRETCH, default 16, number of clk_out rising edges resetn_out stays low after reset release; legal range 1..65535.
REQ-003 Parameter BTN_ACTIVE_HIGH, default 1; 1 = RESET button asserted when high, 0 = asserted when low.
REQ-004 clk  input  1  primary (board) clock; all logic on its rising edge.
REQ-005 resetn  input  1  global reset, synchronous, active-low; clock clk.
REQ-006 RESET  input  1  asynchronous user reset button, polarity per BTN_ACTIVE_HIGH.
REQ-007 clk_out  output  1  divided clock, 50% duty, driven directly by a register bit.
REQ-008 resetn_out  output  1  stretched active-low reset for logic clocked by clk_out; registered.
REQ-009 tick  output  1  one-clk-cycle strobe, high in the clk cycle immediately before each clk_out rising edge.

Function
REQ-010 Divider: free-running (SLOW+1)-bit up-counter cnt, +1 every clk edge, wraps from all-ones to 0.
REQ-011 clk_out SHALL equal cnt[SLOW]; it rises on the edge where cnt goes 2^SLOW-1 -> 2^SLOW and falls on the wrap to 0.
REQ-012 tick SHALL be the combinational decode cnt == 2^SLOW-1 (for SLOW=0: cnt == 0).
REQ-013 RESET SHALL pass through a 2-flop synchronizer into btn_sync (active-high internal sense after polarity correction); no other logic samples RESET directly.
REQ-014 Stretch counter scnt (16 bits): cleared on any clk edge where btn_sync is asserted; otherwise increments on edges where tick is high and resetn_out is low.
REQ-015 resetn_out SHALL be set to 1 on the clk edge where tick is high, btn_sync is deasserted and scnt == RST_STRETCH-1, so it rises coincident with a clk_out rising edge.
REQ-016 resetn_out SHALL be cleared to 0 on the clk edge after btn_sync becomes asserted (3rd clk edge after RESET asserts, given setup met), and remains 0 while btn_sync is asserted.
REQ-017 Button release SHALL restart stretching from scnt = 0; a button pulse of any length of at least 2 clk cycles SHALL produce a full RST_STRETCH stretch.
REQ-018 Button activity SHALL NOT disturb cnt, clk_out or tick.
REQ-019 Once set, resetn_out stays 1 until resetn or the button reasserts reset; scnt does not change while resetn_out is 1.
REQ-020 Pulses shorter than one clk period on RESET MAY be missed; no glitch on any output is permitted as a result.

Reset
REQ-021 While resetn = 0 at a clk edge: cnt = 0, clk_out = 0, tick = 0 for SLOW >= 1 (SLOW=0: 1), synchronizer flops = deasserted, scnt = 0, resetn_out = 0.
REQ-022 resetn assertion mid-operation SHALL take effect on the next clk edge regardless of cnt, scnt or button state; resetn has priority over all other events.
REQ-023 Outputs after power-up without resetn SHALL reach the REQ-021 values on the first sampled resetn = 0; initial-value registers are not required.

Verification
REQ-024 SLOW=2, RST_STRETCH=2, RESET inactive, resetn low 3 edges then high -> cnt at edge k after release = k mod 8; clk_out rises at edges 4, 12, 20; tick high in cycles with cnt = 3.
REQ-025 Same setup -> resetn_out 0 through edge 11, rises at edge 12 coincident with the 2nd clk_out rise, stays 1 thereafter.
REQ-026 After REQ-025, RESET asserted for 20 clk cycles -> resetn_out falls at 3rd edge after assertion; after release rises on the 2nd clk_out rising edge following btn_sync deassertion; clk_out sequence unchanged.
REQ-027 SLOW=0 -> clk_out toggles every clk edge (f/2), tick high every other cycle when cnt = 0.
REQ-028 BTN_ACTIVE_HIGH=0 with RESET held 1 -> behaves as REQ-025; driving RESET 0 asserts button reset.
REQ-029 resetn pulled low mid-stretch (scnt = 1) and mid-count (cnt = 5) -> next edge cnt = 0, scnt = 0, clk_out = 0, resetn_out = 0; sequence of REQ-024/025 then restarts from release.

Source files
------------

// File: rtl/clock_works.sv
// Clock divider with a tick strobe one cycle ahead of each divided rising edge,
// and a reset stretcher that holds resetn_out low for RST_STRETCH clk_out rises.
module clock_works #(
    parameter int SLOW            = 19,
    parameter int RST_STRETCH     = 16,
    parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic RESET,
    output logic clk_out,
    output logic resetn_out,
    output logic tick
);

    localparam int TICK_INT = (1 << SLOW) - 1;
    localparam logic [SLOW:0] TICK_AT = TICK_INT[SLOW:0];
    localparam int LAST_INT = RST_STRETCH - 1;
    localparam logic [15:0] STRETCH_LAST = LAST_INT[15:0];

    logic [SLOW:0] cnt;
    logic          btn_raw;
    logic          btn_meta;
    logic          btn_sync;
    logic [15:0]   scnt;
    logic          rn_q;

    assign btn_raw = BTN_ACTIVE_HIGH ? RESET : ~RESET;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign clk_out = cnt[SLOW];
    assign tick    = (cnt == TICK_AT);

    // Two-flop synchronizer; the button is only ever seen through btn_sync.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            scnt <= '0;
            rn_q <= 1'b0;
        end else if (btn_sync) begin
            scnt <= '0;
            rn_q <= 1'b0;
        end else if (tick && !rn_q) begin
            scnt <= scnt + 16'd1;
            // Release lands on the edge where clk_out rises.
            if (scnt == STRETCH_LAST) begin
                rn_q <= 1'b1;
            end
        end
    end

    assign resetn_out = rn_q;

endmodule

// File: tb/tb_clock_works.sv
// Directed bench for clock_works: divider timing, reset stretch, button
// reset in both polarities, SLOW=0 corner and mid-operation resetn.
module tb_clock_works;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic btn_a = 1'b0;
    logic btn_b = 1'b1;
    logic btn_z = 1'b0;

    logic clk_out_a, rn_a, tick_a;
    logic clk_out_b, rn_b, tick_b;
    logic clk_out_z, rn_z, tick_z;

    int checks = 0;
    int errors = 0;
    int cur_k  = 0;

    always #5 clk = ~clk;

    clock_works #(.SLOW(2), .RST_STRETCH(2), .BTN_ACTIVE_HIGH(1'b1)) u_a (
        .clk(clk), .resetn(resetn), .RESET(btn_a),
        .clk_out(clk_out_a), .resetn_out(rn_a), .tick(tick_a)
    );

    clock_works #(.SLOW(2), .RST_STRETCH(2), .BTN_ACTIVE_HIGH(1'b0)) u_b (
        .clk(clk), .resetn(resetn), .RESET(btn_b),
        .clk_out(clk_out_b), .resetn_out(rn_b), .tick(tick_b)
    );

    clock_works #(.SLOW(0), .RST_STRETCH(2), .BTN_ACTIVE_HIGH(1'b1)) u_z (
        .clk(clk), .resetn(resetn), .RESET(btn_z),
        .clk_out(clk_out_z), .resetn_out(rn_z), .tick(tick_z)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got %b expected %b", tag, cur_k, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold resetn low for n edges, checking reset values after each one.
    task automatic do_reset(input int n);
        resetn = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            cur_k = -1;
            chk("rst_clk_a",  clk_out_a, 1'b0);
            chk("rst_tick_a", tick_a,    1'b0);
            chk("rst_rn_a",   rn_a,      1'b0);
            chk("rst_clk_b",  clk_out_b, 1'b0);
            chk("rst_rn_b",   rn_b,      1'b0);
            chk("rst_clk_z",  clk_out_z, 1'b0);
            chk("rst_tick_z", tick_z,    1'b1);
            chk("rst_rn_z",   rn_z,      1'b0);
        end
        resetn = 1'b1;
    endtask

    // k = edge number after resetn release. With the button run, the button is
    // asserted for edges 25..44: resetn_out drops at 27 and is back at 60.
    task automatic run(input int n, input bit with_btn);
        logic exp_rn;
        for (int k = 1; k <= n; k++) begin
            if (with_btn && k == 25) begin
                btn_a = 1'b1;
                btn_b = 1'b0;
            end
            if (with_btn && k == 45) begin
                btn_a = 1'b0;
                btn_b = 1'b1;
            end
            step();
            cur_k = k;
            exp_rn = (k >= 12) && !(with_btn && k >= 27 && k < 60);
            chk("clk_a",  clk_out_a, (k % 8) >= 4);
            chk("tick_a", tick_a,    (k % 8) == 3);
            chk("rn_a",   rn_a,      exp_rn);
            chk("clk_b",  clk_out_b, (k % 8) >= 4);
            chk("tick_b", tick_b,    (k % 8) == 3);
            chk("rn_b",   rn_b,      exp_rn);
            chk("clk_z",  clk_out_z, (k % 2) == 1);
            chk("tick_z", tick_z,    (k % 2) == 0);
            chk("rn_z",   rn_z,      k >= 3);
        end
    endtask

    initial begin
        do_reset(3);
        run(70, 1'b1);
        do_reset(3);
        // Stop after edge 5: cnt = 5, scnt = 1 in the SLOW=2 instances.
        run(5, 1'b0);
        do_reset(1);
        run(24, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
